// File: rtl/rcb_led_pkg.sv
// Shared encodings and helpers for the RCB status LED arbiter.
package rcb_led_pkg;

    localparam logic [1:0] PAT_OFF  = 2'b00;
    localparam logic [1:0] PAT_ON   = 2'b01;
    localparam logic [1:0] PAT_SLOW = 2'b10;
    localparam logic [1:0] PAT_FAST = 2'b11;

    localparam int SLOW_BIT = 8;
    localparam int FAST_BIT = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } led_state_e;

    // Phase 0 is always the on half of a blink, so each grant opens lit.
    function automatic logic pat_led(input logic [1:0] pat, input logic [9:0] phase);
        case (pat)
            PAT_OFF:  return 1'b0;
            PAT_ON:   return 1'b1;
            PAT_SLOW: return ~phase[SLOW_BIT];
            default:  return ~phase[FAST_BIT];
        endcase
    endfunction

endpackage

// File: rtl/rcb_tick_gen.sv
// Shared prescaler: tick is high for one cycle every TICK_DIV cycles.
module rcb_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk_100m,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/rcb_led_arbiter.sv
// Fixed-priority owner selection for the board status LED with a minimum
// display time per grant; drives the LED from the latched owner pattern.
module rcb_led_arbiter
    import rcb_led_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TICK_DIV   = 100000,
    parameter int HOLD_TICKS = 500
) (
    input  logic                 clk_100m,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   pattern,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 led,
    output led_state_e           state
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

    logic [IW-1:0] own_idx;
    logic [1:0]    cur_pat;
    logic [HW-1:0] hold_cnt;
    logic [9:0]    phase_cnt;
    logic [9:0]    phase_next;

    logic          tick;
    logic          hold_done;
    logic          any_req;
    logic [IW-1:0] win_idx;
    logic [1:0]    win_pat;
    logic          take;
    logic          drop;

    always_comb begin
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) win_idx = IW'(i);
        end
    end

    assign any_req    = |req;
    assign win_pat    = pattern[2*win_idx +: 2];
    assign hold_done  = (hold_cnt == HOLD_MAX);
    assign phase_next = phase_cnt + {9'd0, tick};

    // Once held long enough, the priority winner is the rightful owner; a new
    // winner or a new pattern from the same owner both restart the display.
    assign take = ((state == IDLE) && any_req) ||
                  ((state == SHOW) && hold_done && any_req &&
                   ((win_idx != own_idx) || (win_pat != cur_pat)));
    assign drop = (state == SHOW) && hold_done && !any_req;

    rcb_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk_100m (clk_100m),
        .rst      (rst),
        .clr      ((state == IDLE) || take),
        .tick     (tick)
    );

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            led       <= 1'b0;
            own_idx   <= '0;
            cur_pat   <= PAT_OFF;
            hold_cnt  <= '0;
            phase_cnt <= '0;
        end else if (take) begin
            state     <= SHOW;
            grant     <= N_REQ'(1) << win_idx;
            busy      <= 1'b1;
            led       <= pat_led(win_pat, 10'd0);
            own_idx   <= win_idx;
            cur_pat   <= win_pat;
            hold_cnt  <= '0;
            phase_cnt <= '0;
        end else if ((state == SHOW) && !drop) begin
            phase_cnt <= phase_next;
            led       <= pat_led(cur_pat, phase_next);
            if (tick && !hold_done) hold_cnt <= hold_cnt + 1'b1;
        end else begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            led       <= 1'b0;
            hold_cnt  <= '0;
            phase_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_rcb_led_arbiter.sv
// Directed bench for rcb_led_arbiter with a short tick and hold.
module tb_rcb_led_arbiter;
    import rcb_led_pkg::*;

    localparam int N_REQ      = 4;
    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 3;

    logic             clk_100m = 1'b0;
    logic             rst      = 1'b1;
    logic [N_REQ-1:0] req      = '0;
    logic [7:0]       pattern  = '0;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             led;
    led_state_e       state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] pattern;
        logic [3:0] grant;
        logic       busy;
        logic       led;
    } vec_t;

    vec_t vecs[6];

    always #5 clk_100m = ~clk_100m;

    rcb_led_arbiter #(
        .N_REQ      (N_REQ),
        .TICK_DIV   (TICK_DIV),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk_100m (clk_100m),
        .rst      (rst),
        .req      (req),
        .pattern  (pattern),
        .grant    (grant),
        .busy     (busy),
        .led      (led),
        .state    (state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic step();
        @(posedge clk_100m);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        req     = '0;
        pattern = '0;
        rst     = 1'b1;
        step();
        rst     = 1'b0;
        cyc     = 0;
    endtask

    initial begin
        vecs[0] = '{4'b0001, 8'b11_11_11_00, 4'b0001, 1'b1, 1'b0};
        vecs[1] = '{4'b1010, 8'b00_00_10_00, 4'b0010, 1'b1, 1'b1};
        vecs[2] = '{4'b1000, 8'b11_00_00_00, 4'b1000, 1'b1, 1'b1};
        vecs[3] = '{4'b0110, 8'b00_00_01_00, 4'b0010, 1'b1, 1'b1};
        vecs[4] = '{4'b0000, 8'b11_11_11_11, 4'b0000, 1'b0, 1'b0};
        vecs[5] = '{4'b1111, 8'b01_01_01_10, 4'b0001, 1'b1, 1'b1};

        // Reset and idle
        #2;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_led", led, 1'b0);
        do_reset();
        run_to(10);
        chk("idle_grant", grant, 4'b0000);
        chk("idle_busy", busy, 1'b0);
        chk("idle_led", led, 1'b0);
        chk("idle_state", state, IDLE);

        // First grant out of IDLE
        for (int i = 0; i < 6; i++) begin
            do_reset();
            req     = vecs[i].req;
            pattern = vecs[i].pattern;
            step();
            chk($sformatf("vec%0d_grant", i), grant, vecs[i].grant);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_led", i), led, vecs[i].led);
        end

        // Basic grant, fast blink
        do_reset();
        req     = 4'b0010;
        pattern = 8'b00_00_11_00;
        run_to(1);
        chk("basic_grant", grant, 4'b0010);
        chk("basic_led1", led, 1'b1);
        run_to(256);
        chk("basic_led256", led, 1'b1);
        run_to(257);
        chk("basic_led257", led, 1'b0);
        run_to(512);
        chk("basic_led512", led, 1'b0);
        run_to(513);
        chk("basic_led513", led, 1'b1);
        chk("basic_grant513", grant, 4'b0010);

        // Hold blocks preemption
        do_reset();
        req     = 4'b0010;
        pattern = 8'b00_00_01_11;
        run_to(3);
        req = 4'b0011;
        run_to(13);
        chk("hold_grant13", grant, 4'b0010);
        run_to(14);
        chk("hold_grant14", grant, 4'b0001);
        chk("hold_led14", led, 1'b1);
        chk("hold_busy14", busy, 1'b1);

        // Owner drop with nobody waiting
        do_reset();
        req     = 4'b0100;
        pattern = 8'b00_01_00_00;
        run_to(2);
        req = 4'b0000;
        run_to(13);
        chk("drop_led13", led, 1'b1);
        chk("drop_grant13", grant, 4'b0100);
        run_to(14);
        chk("drop_grant14", grant, 4'b0000);
        chk("drop_busy14", busy, 1'b0);
        chk("drop_led14", led, 1'b0);
        chk("drop_state14", state, IDLE);

        // Owner drop hands over to a lower-priority requester without a gap
        do_reset();
        req     = 4'b0110;
        pattern = 8'b00_00_01_01;
        run_to(2);
        req = 4'b0100;
        run_to(14);
        chk("handoff_grant14", grant, 4'b0100);
        chk("handoff_busy14", busy, 1'b1);
        chk("handoff_led14", led, 1'b0);

        // Drop and higher-priority request land on the hold_done cycle
        do_reset();
        req     = 4'b0010;
        pattern = 8'b00_00_01_01;
        run_to(13);
        req = 4'b0001;
        run_to(14);
        chk("coinc_grant14", grant, 4'b0001);

        // Pattern change after hold
        do_reset();
        req     = 4'b0001;
        pattern = 8'b00_00_00_01;
        run_to(20);
        pattern = 8'b00_00_00_10;
        run_to(21);
        chk("pchg_grant21", grant, 4'b0001);
        chk("pchg_led21", led, 1'b1);
        run_to(21 + 1023);
        chk("pchg_led1044", led, 1'b1);
        run_to(21 + 1024);
        chk("pchg_led1045", led, 1'b0);

        // Async reset mid-SHOW
        do_reset();
        req     = 4'b0001;
        pattern = 8'b00_00_00_11;
        run_to(5);
        chk("arst_led_before", led, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", grant, 4'b0000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_led", led, 1'b0);
        #1 rst = 1'b0;
        step();
        chk("arst_regrant", grant, 4'b0001);
        chk("arst_reled", led, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rcb_led_arbiter.md
# rcb_led_arbiter

Shares the board status LED between several RCB status sources. Each source can request the LED with a blink pattern. Arbitration is fixed-priority with a guaranteed minimum display time, so every granted pattern stays visible long enough for an operator to read it. The block sits between the RCB status/diagnostic logic and the LED pin, and replaces free-running per-LED blink counters with one shared prescaler and pattern generator.

## Interface
- N_REQ, 4: number of requesters; index 0 has the highest priority.
- TICK_DIV, 100000: clk_100m cycles per pattern tick (1 ms at 100 MHz).
- HOLD_TICKS, 500: minimum ticks a grant is held before re-arbitration.
- clk_100m  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level request per source.
- pattern  in  2*N_REQ  per-source pattern; bits [2i+1:2i] belong to source i.
  - 00 off, 01 solid on, 10 slow blink, 11 fast blink.
- grant  out  N_REQ  one-hot current owner; all zeros when idle.
- busy  out  1  high while any grant is active.
- led  out  1  LED drive, active high.

## Operation
- States: IDLE and SHOW.
- **Reset:** state=IDLE; grant=0, busy=0, led=0; all counters 0.
- **IDLE:** led=0.
  - If any req bit is high, grant the lowest set index.
  - Latch that source's pattern into cur_pat.
  - Clear the prescaler, hold_cnt and phase_cnt, then go to SHOW.
- **SHOW:** prescaler counts 0..TICK_DIV-1 and wraps; tick is high in the cycle the prescaler equals TICK_DIV-1.
  - On each tick, phase_cnt (10 bits, wraps 1023→0) increments.
  - On each tick, hold_cnt increments and saturates at HOLD_TICKS.
  - hold_done = (hold_cnt == HOLD_TICKS).
- **Pattern output, from cur_pat:**
  - 00 → led=0.
  - 01 → led=1.
  - 10 → led=~phase_cnt[8], i.e. 256 ticks on, 256 off.
  - 11 → led=~phase_cnt[6], i.e. 64 ticks on, 64 off.
  - Every grant starts in the on phase.
- **Before hold_done:**
  - The grant is never changed, even if the owner drops req or a higher-priority req rises.
  - The pattern input is ignored; the display stays latched in cur_pat.
- **After hold_done, re-evaluated every cycle:**
  - Higher-priority req high → re-grant to the highest-priority requester.
  - Owner req low and another req high → re-grant to the lowest set index.
  - Owner req low and no req high → go to IDLE.
  - Owner req high and its pattern differs from cur_pat → re-grant the same owner with the new pattern.
  - Otherwise → keep the grant; counters keep running and hold_cnt stays saturated.
- **Re-grant:** reload cur_pat, clear all three counters, stay in SHOW.
- **Requester rules:**
  - A requester with pattern 00 legitimately owns a dark LED.
  - req bits are not latched; a pulse that is shorter than the wait and falls before arbitration is lost.

## Timing
- **Request to grant:** a req sampled high in IDLE at cycle t gives grant, busy and led valid at t+1. All outputs are registered.
- **Hold expiry:** the first tick comes TICK_DIV cycles after the grant. hold_done is first high at cycle t+1+HOLD_TICKS*TICK_DIV.
- **Re-arbitration:** a decision taken in cycle c becomes visible at c+1. There is no idle gap between owners.
- **Simultaneous events:**
  - A req edge in the same cycle hold_done first asserts is counted in the decision.
  - If owner drop and a higher-priority request coincide, the higher priority wins.
- **Reset mid-SHOW:** the outputs clear immediately, asynchronously. The first grant after reset release follows the IDLE rule.
- **Counter widths:**
  - prescaler: $clog2(TICK_DIV).
  - hold_cnt: $clog2(HOLD_TICKS+1).
  - phase_cnt: fixed 10 bits.
  - Legal parameter ranges: TICK_DIV ≥ 2, HOLD_TICKS ≥ 1.

## Structure
- Package rcb_led_pkg holds:
  - Pattern encodings PAT_OFF, PAT_ON, PAT_SLOW, PAT_FAST.
  - The state enum (IDLE, SHOW).
  - Phase bit indices SLOW_BIT=8 and FAST_BIT=6.
- Sub-module rcb_tick_gen: prescaler with a synchronous clear input and a tick output, parameterized by TICK_DIV.
- Arbiter, state machine, hold/phase counters and pattern mux live in rcb_led_arbiter.

## Test plan
Bench parameters: TICK_DIV=4, HOLD_TICKS=3, N_REQ=4.

- **Reset and idle:** with rst high and then released with no req, grant=0, busy=0, led=0 indefinitely.
- **Basic grant:** req=0010 and pattern[3:2]=11 at cycle 0 →
  - At cycle 1, grant=0010, busy=1, led=1.
  - led falls at cycle 257 (64 ticks × 4 cycles) and rises again at cycle 513.
- **Hold blocks preemption:** source 1 is granted at cycle 1 and req[0] rises at cycle 3 →
  - grant stays 0010 through cycle 13.
  - At cycle 14, grant=0001 with led restarting in the on phase.
- **Owner drop:** source 2 with pattern 01 is granted at cycle 1, and req[2] falls at cycle 2 while no other req is high →
  - led=1 until cycle 13.
  - At cycle 14, state is IDLE with grant=0, led=0, busy=0.
- **Pattern change after hold:** the owner switches its pattern from 01 to 10 at cycle 20 →
  - At cycle 21, the same grant is re-issued, led=1, and the counters are cleared.
  - led falls at cycle 21+1024.
- **Async reset mid-SHOW:** asserting rst during a fast blink clears grant, busy and led in the same cycle. After release with req held, the grant returns one cycle after the first sampling edge.
